// File: rtl/pc_sequencer_if.sv
// Fetch/control bundle between the branch-decision logic, the PC stage and
// instruction memory. The sequencer side is the fetch master.
interface pc_sequencer_if;
  logic        stall_i;
  logic        taken_i;
  logic        jal_i;
  logic        jalr_i;
  logic [31:0] imm_i;
  logic [31:0] rs1_i;
  logic        fetch_ready_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        fetch_valid_o;
  logic        retire_o;
  logic [31:0] retire_count_o;
  logic        fault_o;
  logic [31:0] fault_addr_o;

  modport master (
    input  stall_i, taken_i, jal_i, jalr_i, imm_i, rs1_i, fetch_ready_i,
    output pc_o, pc_plus4_o, fetch_valid_o, retire_o, retire_count_o,
           fault_o, fault_addr_o
  );

  modport slave (
    output stall_i, taken_i, jal_i, jalr_i, imm_i, rs1_i, fetch_ready_i,
    input  pc_o, pc_plus4_o, fetch_valid_o, retire_o, retire_count_o,
           fault_o, fault_addr_o
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter stage: selects and registers the next PC, drives the fetch
// request, traps misaligned control-flow targets and counts retirements.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  pc_sequencer_if.master bus
);

  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q;
  logic        fetch_valid_q;
  logic        retire_q;
  logic [31:0] retire_cnt_q;
  logic        fault_q;
  logic [31:0] fault_addr_q;

  logic [31:0] jalr_sum;
  logic [31:0] target;
  logic        misaligned;
  logic        advance;

  // Target selection (JALR > JAL > taken branch > sequential) and next state.
  always_comb begin
    state_d    = state_q;
    jalr_sum   = bus.rs1_i + bus.imm_i;
    target     = pc_q + 32'd4;
    if (bus.jalr_i) begin
      target = {jalr_sum[31:1], 1'b0};
    end else if (bus.jal_i || bus.taken_i) begin
      target = pc_q + bus.imm_i;
    end
    misaligned = target[1];
    advance    = (state_q == RUN) && fetch_valid_q && bus.fetch_ready_i && !bus.stall_i;

    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (advance && misaligned) state_d = FAULT;
      FAULT:   state_d = FAULT;
      default: state_d = BOOT;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // PC, fetch request, retire pulse/counter and fault capture.
  // The fetch request is registered, so it rises only once the FSM has already
  // been in RUN for a full cycle, and drops on the same edge that enters FAULT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q          <= RESET_VECTOR;
      fetch_valid_q <= 1'b0;
      retire_q      <= 1'b0;
      retire_cnt_q  <= '0;
      fault_q       <= 1'b0;
      fault_addr_q  <= '0;
    end else begin
      fetch_valid_q <= (state_q == RUN) && (state_d == RUN);
      retire_q      <= 1'b0;
      if (advance) begin
        if (misaligned) begin
          fault_q      <= 1'b1;
          fault_addr_q <= target;
        end else begin
          pc_q         <= target;
          retire_q     <= 1'b1;
          retire_cnt_q <= retire_cnt_q + 32'd1;
        end
      end
    end
  end

  assign bus.pc_o           = pc_q;
  assign bus.pc_plus4_o     = pc_q + 32'd4;
  assign bus.fetch_valid_o  = fetch_valid_q;
  assign bus.retire_o       = retire_q;
  assign bus.retire_count_o = retire_cnt_q;
  assign bus.fault_o        = fault_q;
  assign bus.fault_addr_o   = fault_addr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a reference model predicts each
// retirement when stimulus is driven and queues it; retirements seen on the
// DUT are popped and compared.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0100;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] cnt;
  } retire_t;

  logic clk;
  logic rst_n;
  pc_sequencer_if bus();

  pc_sequencer #(.RESET_VECTOR(RV)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  retire_t     sb_q[$];
  // reference model: 0 BOOT, 1 RUN, 2 FAULT
  int unsigned m_state;
  logic        m_fv;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_fault;
  logic [31:0] m_faddr;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_fv    = 1'b0;
    m_pc    = RV;
    m_cnt   = '0;
    m_fault = 1'b0;
    m_faddr = '0;
    sb_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pc"},    bus.pc_o, RV);
    check({tag, "_pc4"},   bus.pc_plus4_o, RV + 32'd4);
    check({tag, "_fv"},    {31'd0, bus.fetch_valid_o}, 32'd0);
    check({tag, "_ret"},   {31'd0, bus.retire_o}, 32'd0);
    check({tag, "_cnt"},   bus.retire_count_o, 32'd0);
    check({tag, "_flt"},   {31'd0, bus.fault_o}, 32'd0);
    check({tag, "_faddr"}, bus.fault_addr_o, 32'd0);
  endtask

  // Called at posedge+1: drive one cycle of inputs, predict, wait an edge, compare.
  task automatic step(input logic stall, input logic ready, input logic taken,
                      input logic jal, input logic jalr,
                      input logic [31:0] imm, input logic [31:0] rs1);
    logic        adv;
    logic        exp_ret;
    logic [31:0] tgt;
    logic [31:0] sum;
    int unsigned nxt;
    retire_t     e;
    bus.stall_i       = stall;
    bus.fetch_ready_i = ready;
    bus.taken_i       = taken;
    bus.jal_i         = jal;
    bus.jalr_i        = jalr;
    bus.imm_i         = imm;
    bus.rs1_i         = rs1;

    adv = (m_state == 1) && m_fv && ready && !stall;
    sum = rs1 + imm;
    if (jalr)              tgt = sum & 32'hFFFF_FFFE;
    else if (jal || taken) tgt = m_pc + imm;
    else                   tgt = m_pc + 32'd4;

    nxt = m_state;
    if (m_state == 0) nxt = 1;
    else if (m_state == 1 && adv && tgt[1]) nxt = 2;

    exp_ret = 1'b0;
    if (adv && !tgt[1]) begin
      m_pc  = tgt;
      m_cnt = m_cnt + 32'd1;
      e.pc  = tgt;
      e.cnt = m_cnt;
      sb_q.push_back(e);
      exp_ret = 1'b1;
    end else if (adv) begin
      m_fault = 1'b1;
      m_faddr = tgt;
    end
    m_fv    = (m_state == 1) && (nxt == 1);
    m_state = nxt;

    @(posedge clk);
    #1;
    check("retire", {31'd0, bus.retire_o}, {31'd0, exp_ret});
    if (bus.retire_o) begin
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("sb_pc",  bus.pc_o, e.pc);
        check("sb_cnt", bus.retire_count_o, e.cnt);
      end else begin
        check("sb_underflow", sb_q.size(), 1);
      end
    end
    check("pc",    bus.pc_o, m_pc);
    check("pc4",   bus.pc_plus4_o, m_pc + 32'd4);
    check("fv",    {31'd0, bus.fetch_valid_o}, {31'd0, m_fv});
    check("fault", {31'd0, bus.fault_o}, {31'd0, m_fault});
    check("faddr", bus.fault_addr_o, m_faddr);
  endtask

  task automatic seq(); step(0, 1, 0, 0, 0, 32'd0, 32'd0); endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic async_reset(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values(tag);
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.stall_i       = 1'b0;
    bus.fetch_ready_i = 1'b1;
    bus.taken_i       = 1'b0;
    bus.jal_i         = 1'b0;
    bus.jalr_i        = 1'b0;
    bus.imm_i         = '0;
    bus.rs1_i         = '0;
    model_reset();

    // reset state and boot
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst");
    release_reset();
    seq();                                   // BOOT edge: fetch_valid still low
    check("boot_fv1", {31'd0, bus.fetch_valid_o}, 32'd0);
    seq();                                   // second edge: fetch_valid rises
    check("boot_fv2", {31'd0, bus.fetch_valid_o}, 32'd1);
    seq();
    check("boot_pc1", bus.pc_o, 32'h104);
    seq();
    check("boot_pc2", bus.pc_o, 32'h108);
    check("boot_cnt", bus.retire_count_o, 32'd2);

    // branch / jump priority
    step(0, 1, 0, 0, 1, 32'd0, 32'h200);
    check("to_200", bus.pc_o, 32'h200);
    step(0, 1, 1, 0, 0, 32'hFFFF_FFF8, 32'd0);
    check("taken_neg", bus.pc_o, 32'h1F8);
    step(0, 1, 1, 1, 0, 32'h40, 32'd0);
    check("jal_wins", bus.pc_o, 32'h238);
    step(0, 1, 0, 0, 1, 32'd0, 32'h1001);
    check("jalr_bit0", bus.pc_o, 32'h1000);
    // JAL target 0x1002 would fault, but JALR is selected and aligned
    step(0, 1, 1, 1, 1, 32'd2, 32'h3002);
    check("jalr_prio", bus.pc_o, 32'h3004);
    check("jalr_prio_flt", {31'd0, bus.fault_o}, 32'd0);

    // stall then fetch_ready low, branch held throughout
    repeat (3) step(1, 1, 1, 0, 0, 32'h10, 32'd0);
    step(1, 0, 1, 0, 0, 32'h10, 32'd0);
    step(0, 0, 1, 0, 0, 32'h10, 32'd0);
    check("hold_pc", bus.pc_o, 32'h3004);
    check("hold_fv", {31'd0, bus.fetch_valid_o}, 32'd1);
    step(0, 1, 1, 0, 0, 32'h10, 32'd0);
    check("hold_apply", bus.pc_o, 32'h3014);

    // misaligned fault
    step(0, 1, 0, 0, 1, 32'd0, 32'h300);
    step(0, 1, 0, 1, 0, 32'd6, 32'd0);
    check("flt_set", {31'd0, bus.fault_o}, 32'd1);
    check("flt_addr", bus.fault_addr_o, 32'h306);
    check("flt_pc", bus.pc_o, 32'h300);
    check("flt_fv", {31'd0, bus.fetch_valid_o}, 32'd0);
    repeat (3) step(0, 1, 1, 1, 1, 32'd8, 32'h500);
    check("flt_stuck_pc", bus.pc_o, 32'h300);

    // asynchronous reset out of FAULT
    async_reset("rst_flt");
    release_reset();
    seq();
    seq();

    // PC wrap
    step(0, 1, 0, 0, 1, 32'd0, 32'hFFFF_FFFC);
    seq();
    check("pc_wrap", bus.pc_o, 32'h0);
    check("pc_wrap_flt", {31'd0, bus.fault_o}, 32'd0);

    // retire counter wrap via backdoor preload
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    #1;
    seq();
    check("cnt_wrap", bus.retire_count_o, 32'd0);

    // asynchronous reset mid-run at count 5
    async_reset("rst_mid0");
    release_reset();
    seq();
    seq();
    repeat (5) seq();
    check("mid_cnt", bus.retire_count_o, 32'd5);
    async_reset("rst_mid");
    @(posedge clk);
    #1;
    check("rst_hold_pc", bus.pc_o, RV);

    check("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
